// File: rtl/hazard_tracker.sv
// hazard_tracker: shadows the EX/MEM/WB destination tags for the forwarding unit and
// resolves load-use stalls, mispredict flushes and WB-to-ID register-file bypass.
module hazard_tracker #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_rd_wren_i,
    input  logic             id_is_load_i,
    input  logic             mispredict_i,
    input  logic             mem_stall_i,
    output logic [4:0]       ex_rs1_addr_o,
    output logic [4:0]       ex_rs2_addr_o,
    output logic [4:0]       mem_rd_addr_o,
    output logic [4:0]       wb_rd_addr_o,
    output logic             mem_rd_wren_o,
    output logic             wb_rd_wren_o,
    output logic             load_use_stall_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             id_wb_bypass_rs1_o,
    output logic             id_wb_bypass_rs2_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic tag_hit(input logic used, input logic [4:0] src, input logic [4:0] dst);
        return used & (src == dst);
    endfunction

    logic             ex_valid_r;
    logic [4:0]       ex_rd_addr_r;
    logic             ex_rd_wren_r;
    logic [4:0]       ex_rs1_addr_r;
    logic [4:0]       ex_rs2_addr_r;
    logic             ex_is_load_r;
    logic             mem_valid_r;
    logic [4:0]       mem_rd_addr_r;
    logic             mem_rd_wren_r;
    logic             wb_valid_r;
    logic [4:0]       wb_rd_addr_r;
    logic             wb_rd_wren_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic             load_use_raw_s;
    logic             flush_evt_s;
    logic             stall_evt_s;
    logic             bypass_rs1_s;
    logic             bypass_rs2_s;

    logic             ex_valid_nx_s;
    logic [4:0]       ex_rd_addr_nx_s;
    logic             ex_rd_wren_nx_s;
    logic [4:0]       ex_rs1_addr_nx_s;
    logic [4:0]       ex_rs2_addr_nx_s;
    logic             ex_is_load_nx_s;

    // Hazard classification; mem stall outranks mispredict, which outranks load-use.
    always_comb begin
        load_use_raw_s = id_valid_i & ex_valid_r & ex_is_load_r & ex_rd_wren_r &
                         (tag_hit(id_rs1_used_i, id_rs1_addr_i, ex_rd_addr_r) |
                          tag_hit(id_rs2_used_i, id_rs2_addr_i, ex_rd_addr_r));
        flush_evt_s    = ~mem_stall_i & mispredict_i;
        stall_evt_s    = ~mem_stall_i & ~mispredict_i & load_use_raw_s;
        bypass_rs1_s   = id_valid_i & wb_valid_r & wb_rd_wren_r &
                         tag_hit(id_rs1_used_i, id_rs1_addr_i, wb_rd_addr_r);
        bypass_rs2_s   = id_valid_i & wb_valid_r & wb_rd_wren_r &
                         tag_hit(id_rs2_used_i, id_rs2_addr_i, wb_rd_addr_r);
    end

    // Next EX tag: a bubble on flush, stall or empty ID slot; x0 is never marked as written.
    always_comb begin
        ex_valid_nx_s    = 1'b0;
        ex_rd_addr_nx_s  = 5'd0;
        ex_rd_wren_nx_s  = 1'b0;
        ex_rs1_addr_nx_s = 5'd0;
        ex_rs2_addr_nx_s = 5'd0;
        ex_is_load_nx_s  = 1'b0;
        if (id_valid_i & ~flush_evt_s & ~stall_evt_s) begin
            ex_valid_nx_s    = 1'b1;
            ex_rd_addr_nx_s  = id_rd_addr_i;
            ex_rd_wren_nx_s  = id_rd_wren_i & (id_rd_addr_i != 5'd0);
            ex_rs1_addr_nx_s = id_rs1_used_i ? id_rs1_addr_i : 5'd0;
            ex_rs2_addr_nx_s = id_rs2_used_i ? id_rs2_addr_i : 5'd0;
            ex_is_load_nx_s  = id_is_load_i;
        end else begin
            ex_valid_nx_s    = 1'b0;
            ex_rd_addr_nx_s  = 5'd0;
            ex_rd_wren_nx_s  = 1'b0;
            ex_rs1_addr_nx_s = 5'd0;
            ex_rs2_addr_nx_s = 5'd0;
            ex_is_load_nx_s  = 1'b0;
        end
    end

    // Tag pipeline: advances every cycle except while data memory stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_r    <= 1'b0;
            ex_rd_addr_r  <= 5'd0;
            ex_rd_wren_r  <= 1'b0;
            ex_rs1_addr_r <= 5'd0;
            ex_rs2_addr_r <= 5'd0;
            ex_is_load_r  <= 1'b0;
            mem_valid_r   <= 1'b0;
            mem_rd_addr_r <= 5'd0;
            mem_rd_wren_r <= 1'b0;
            wb_valid_r    <= 1'b0;
            wb_rd_addr_r  <= 5'd0;
            wb_rd_wren_r  <= 1'b0;
        end else if (!mem_stall_i) begin
            ex_valid_r    <= ex_valid_nx_s;
            ex_rd_addr_r  <= ex_rd_addr_nx_s;
            ex_rd_wren_r  <= ex_rd_wren_nx_s;
            ex_rs1_addr_r <= ex_rs1_addr_nx_s;
            ex_rs2_addr_r <= ex_rs2_addr_nx_s;
            ex_is_load_r  <= ex_is_load_nx_s;
            mem_valid_r   <= ex_valid_r;
            mem_rd_addr_r <= ex_rd_addr_r;
            mem_rd_wren_r <= ex_rd_wren_r;
            wb_valid_r    <= mem_valid_r;
            wb_rd_addr_r  <= mem_rd_addr_r;
            wb_rd_wren_r  <= mem_rd_wren_r;
        end else begin
            ex_valid_r    <= ex_valid_r;
            ex_rd_addr_r  <= ex_rd_addr_r;
            ex_rd_wren_r  <= ex_rd_wren_r;
            ex_rs1_addr_r <= ex_rs1_addr_r;
            ex_rs2_addr_r <= ex_rs2_addr_r;
            ex_is_load_r  <= ex_is_load_r;
            mem_valid_r   <= mem_valid_r;
            mem_rd_addr_r <= mem_rd_addr_r;
            mem_rd_wren_r <= mem_rd_wren_r;
            wb_valid_r    <= wb_valid_r;
            wb_rd_addr_r  <= wb_rd_addr_r;
            wb_rd_wren_r  <= wb_rd_wren_r;
        end
    end

    // Saturating performance counters; the event signals already exclude stalled cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign ex_rs1_addr_o      = ex_rs1_addr_r;
    assign ex_rs2_addr_o      = ex_rs2_addr_r;
    assign mem_rd_addr_o      = mem_rd_addr_r;
    assign wb_rd_addr_o       = wb_rd_addr_r;
    assign mem_rd_wren_o      = mem_rd_wren_r;
    assign wb_rd_wren_o       = wb_rd_wren_r;
    assign stall_cnt_o        = stall_cnt_r;
    assign flush_cnt_o        = flush_cnt_r;

    // Combinational controls are forced low while reset is asserted.
    assign load_use_stall_o   = ~rst_i & stall_evt_s;
    assign flush_if_id_o      = ~rst_i & flush_evt_s;
    assign flush_id_ex_o      = ~rst_i & (flush_evt_s | stall_evt_s);
    assign id_wb_bypass_rs1_o = ~rst_i & bypass_rs1_s;
    assign id_wb_bypass_rs2_o = ~rst_i & bypass_rs2_s;

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed scenarios plus random traffic against a queue-based
// model of the three in-flight instruction slots.
module tb_hazard_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_wren_i, id_is_load_i;
    logic       mispredict_i, mem_stall_i;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;

    logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, mem_rd_addr_o, wb_rd_addr_o;
    logic        mem_rd_wren_o, wb_rd_wren_o, load_use_stall_o, flush_if_id_o, flush_id_ex_o;
    logic        id_wb_bypass_rs1_o, id_wb_bypass_rs2_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic [4:0] w4_ex_rs1, w4_ex_rs2, w4_mem_rd, w4_wb_rd;
    logic       w4_mem_wren, w4_wb_wren, w4_lu, w4_fi, w4_fe, w4_b1, w4_b2;
    logic [3:0] w4_stall_cnt, w4_flush_cnt;

    hazard_tracker dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i),
        .mispredict_i(mispredict_i), .mem_stall_i(mem_stall_i),
        .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
        .mem_rd_addr_o(mem_rd_addr_o), .wb_rd_addr_o(wb_rd_addr_o),
        .mem_rd_wren_o(mem_rd_wren_o), .wb_rd_wren_o(wb_rd_wren_o),
        .load_use_stall_o(load_use_stall_o), .flush_if_id_o(flush_if_id_o),
        .flush_id_ex_o(flush_id_ex_o), .id_wb_bypass_rs1_o(id_wb_bypass_rs1_o),
        .id_wb_bypass_rs2_o(id_wb_bypass_rs2_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    hazard_tracker #(.CNT_W(4)) dut_w4 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i),
        .mispredict_i(mispredict_i), .mem_stall_i(mem_stall_i),
        .ex_rs1_addr_o(w4_ex_rs1), .ex_rs2_addr_o(w4_ex_rs2),
        .mem_rd_addr_o(w4_mem_rd), .wb_rd_addr_o(w4_wb_rd),
        .mem_rd_wren_o(w4_mem_wren), .wb_rd_wren_o(w4_wb_wren),
        .load_use_stall_o(w4_lu), .flush_if_id_o(w4_fi),
        .flush_id_ex_o(w4_fe), .id_wb_bypass_rs1_o(w4_b1),
        .id_wb_bypass_rs2_o(w4_b2),
        .stall_cnt_o(w4_stall_cnt), .flush_cnt_o(w4_flush_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        bit       valid;
        bit [4:0] rd;
        bit       wren;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       load;
    } slot_t;

    typedef struct packed {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit [4:0] rd;
        bit       w;
        bit       ld;
    } id_t;

    slot_t pipe[$];   // [0]=EX, [1]=MEM, [2]=WB
    int    n_stall;
    int    n_flush;

    function automatic int sat(input int n, input int w);
        int lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    function automatic id_t op_alu(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        return '{v: 1'b1, rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1, rd: rd, w: 1'b1, ld: 1'b0};
    endfunction

    function automatic id_t op_load(input bit [4:0] rd, input bit [4:0] rs1);
        return '{v: 1'b1, rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: rd, w: 1'b1, ld: 1'b1};
    endfunction

    function automatic id_t op_idle();
        return '0;
    endfunction

    function automatic id_t op_rand();
        id_t i;
        i.v   = ($urandom_range(0, 4) != 0);
        i.rs1 = 5'($urandom_range(0, 7));
        i.rs2 = 5'($urandom_range(0, 7));
        i.u1  = 1'($urandom_range(0, 1));
        i.u2  = 1'($urandom_range(0, 1));
        i.rd  = 5'($urandom_range(0, 7));
        i.w   = ($urandom_range(0, 3) != 0);
        i.ld  = ($urandom_range(0, 2) == 0);
        return i;
    endfunction

    task automatic drive(input id_t i, input bit mp, input bit ms);
        id_valid_i    = i.v;
        id_rs1_addr_i = i.rs1;
        id_rs2_addr_i = i.rs2;
        id_rs1_used_i = i.u1;
        id_rs2_used_i = i.u2;
        id_rd_addr_i  = i.rd;
        id_rd_wren_i  = i.w;
        id_is_load_i  = i.ld;
        mispredict_i  = mp;
        mem_stall_i   = ms;
    endtask

    task automatic model_reset();
        pipe.delete();
        repeat (3) pipe.push_back('0);
        n_stall = 0;
        n_flush = 0;
    endtask

    // ID reads a register that the load now in EX is about to write
    function automatic bit lu_now();
        slot_t ex = pipe[0];
        if (!(id_valid_i && ex.valid && ex.load && ex.wren)) return 1'b0;
        return (id_rs1_used_i && id_rs1_addr_i == ex.rd) || (id_rs2_used_i && id_rs2_addr_i == ex.rd);
    endfunction

    task automatic check_outputs();
        slot_t ex, mem, wb;
        bit eli, efi, efe, eb1, eb2;
        logic [26:0] exp_vec, w4_vec;
        ex = pipe[0]; mem = pipe[1]; wb = pipe[2];
        eli = 1'b0; efi = 1'b0; efe = 1'b0; eb1 = 1'b0; eb2 = 1'b0;
        if (!rst_i) begin
            efi = !mem_stall_i && mispredict_i;
            eli = !mem_stall_i && !mispredict_i && lu_now();
            efe = efi || eli;
            eb1 = id_valid_i && id_rs1_used_i && wb.wren && (wb.rd == id_rs1_addr_i);
            eb2 = id_valid_i && id_rs2_used_i && wb.wren && (wb.rd == id_rs2_addr_i);
        end
        check_val("ex_rs1", 32'(ex_rs1_addr_o), 32'(ex.rs1));
        check_val("ex_rs2", 32'(ex_rs2_addr_o), 32'(ex.rs2));
        check_val("mem_rd", 32'(mem_rd_addr_o), 32'(mem.rd));
        check_val("wb_rd", 32'(wb_rd_addr_o), 32'(wb.rd));
        check_val("mem_wren", 32'(mem_rd_wren_o), 32'(mem.wren));
        check_val("wb_wren", 32'(wb_rd_wren_o), 32'(wb.wren));
        check_val("load_use", 32'(load_use_stall_o), 32'(eli));
        check_val("flush_if_id", 32'(flush_if_id_o), 32'(efi));
        check_val("flush_id_ex", 32'(flush_id_ex_o), 32'(efe));
        check_val("bypass_rs1", 32'(id_wb_bypass_rs1_o), 32'(eb1));
        check_val("bypass_rs2", 32'(id_wb_bypass_rs2_o), 32'(eb2));
        check_val("stall_cnt", 32'(stall_cnt_o), 32'(sat(n_stall, 16)));
        check_val("flush_cnt", 32'(flush_cnt_o), 32'(sat(n_flush, 16)));
        exp_vec = {ex.rs1, ex.rs2, mem.rd, wb.rd, mem.wren, wb.wren, eli, efi, efe, eb1, eb2};
        w4_vec  = {w4_ex_rs1, w4_ex_rs2, w4_mem_rd, w4_wb_rd, w4_mem_wren, w4_wb_wren,
                   w4_lu, w4_fi, w4_fe, w4_b1, w4_b2};
        check_val("w4_outputs", 32'(w4_vec), 32'(exp_vec));
        check_val("w4_stall_cnt", 32'(w4_stall_cnt), 32'(sat(n_stall, 4)));
        check_val("w4_flush_cnt", 32'(w4_flush_cnt), 32'(sat(n_flush, 4)));
    endtask

    // what the coming rising edge does to the in-flight instructions
    task automatic model_advance();
        slot_t nx;
        bit lu;
        if (rst_i || mem_stall_i) return;
        lu = lu_now();
        nx = '0;
        if (id_valid_i && !mispredict_i && !lu) begin
            nx.valid = 1'b1;
            nx.rd    = id_rd_addr_i;
            nx.wren  = id_rd_wren_i && (id_rd_addr_i != 5'd0);
            nx.rs1   = id_rs1_used_i ? id_rs1_addr_i : 5'd0;
            nx.rs2   = id_rs2_used_i ? id_rs2_addr_i : 5'd0;
            nx.load  = id_is_load_i;
        end
        if (mispredict_i) n_flush++;
        else if (lu) n_stall++;
        pipe.push_front(nx);
        void'(pipe.pop_back());
    endtask

    task automatic step(input id_t i, input bit mp, input bit ms);
        @(negedge clk);
        drive(i, mp, ms);
        #1;
        check_outputs();
        model_advance();
    endtask

    // reset asserted away from the clock edge with garbage on the inputs
    task automatic do_reset();
        @(negedge clk);
        drive(op_rand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rst_i = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        #1;
        check_outputs();
        drive(op_idle(), 1'b0, 1'b0);
        rst_i = 1'b0;
        #1;
        check_outputs();
        model_advance();
    endtask

    initial begin
        rst_i = 1'b1;
        drive(op_idle(), 1'b0, 1'b0);
        model_reset();

        // reset release, then ADD x5 travels EX -> MEM -> WB
        do_reset();
        check_val("rst_mem_rd", 32'(mem_rd_addr_o), 32'd0);
        check_val("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
        step(op_alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0);
        step(op_idle(), 1'b0, 1'b0);
        step(op_idle(), 1'b0, 1'b0);
        check_val("add_mem_rd", 32'(mem_rd_addr_o), 32'd5);
        check_val("add_mem_wren", 32'(mem_rd_wren_o), 32'd1);
        step(op_idle(), 1'b0, 1'b0);
        check_val("add_wb_rd", 32'(wb_rd_addr_o), 32'd5);

        // LW x7 then ADD x8,x7,x1: one stall cycle
        step(op_load(5'd7, 5'd2), 1'b0, 1'b0);
        step(op_alu(5'd8, 5'd7, 5'd1), 1'b0, 1'b0);
        check_val("lu_stall", 32'(load_use_stall_o), 32'd1);
        check_val("lu_flush_id_ex", 32'(flush_id_ex_o), 32'd1);
        step(op_alu(5'd8, 5'd7, 5'd1), 1'b0, 1'b0);
        check_val("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
        check_val("lu_mem_rd", 32'(mem_rd_addr_o), 32'd7);
        check_val("lu_ex_bubble", 32'(ex_rs1_addr_o), 32'd0);
        check_val("lu_stall_once", 32'(load_use_stall_o), 32'd0);
        step(op_idle(), 1'b0, 1'b0);
        check_val("lu_ex_rs1", 32'(ex_rs1_addr_o), 32'd7);
        check_val("lu_wb_rd", 32'(wb_rd_addr_o), 32'd7);

        // x0 destination never forwards or stalls
        step(op_load(5'd0, 5'd3), 1'b0, 1'b0);
        step(op_alu(5'd9, 5'd0, 5'd0), 1'b0, 1'b0);
        check_val("x0_no_stall", 32'(load_use_stall_o), 32'd0);
        step(op_idle(), 1'b0, 1'b0);
        check_val("x0_mem_wren", 32'(mem_rd_wren_o), 32'd0);
        step(op_idle(), 1'b0, 1'b0);
        check_val("x0_wb_wren", 32'(wb_rd_wren_o), 32'd0);

        // load-use coinciding with mispredict: flush wins
        do_reset();
        step(op_load(5'd7, 5'd2), 1'b0, 1'b0);
        step(op_alu(5'd8, 5'd7, 5'd1), 1'b1, 1'b0);
        check_val("mp_flush_if_id", 32'(flush_if_id_o), 32'd1);
        check_val("mp_flush_id_ex", 32'(flush_id_ex_o), 32'd1);
        check_val("mp_no_stall", 32'(load_use_stall_o), 32'd0);
        step(op_idle(), 1'b0, 1'b0);
        check_val("mp_flush_cnt", 32'(flush_cnt_o), 32'd1);
        check_val("mp_stall_cnt", 32'(stall_cnt_o), 32'd0);

        // mem stall freezes an in-flight x3 write; mispredict held across it counts once
        step(op_alu(5'd3, 5'd4, 5'd5), 1'b0, 1'b0);
        step(op_idle(), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(op_alu(5'd6, 5'd3, 5'd3), 1'b1, 1'b1);
            check_val("ms_mem_rd", 32'(mem_rd_addr_o), 32'd3);
            check_val("ms_mem_wren", 32'(mem_rd_wren_o), 32'd1);
            check_val("ms_flush_cnt", 32'(flush_cnt_o), 32'd1);
            check_val("ms_no_flush", 32'(flush_if_id_o), 32'd0);
        end
        step(op_idle(), 1'b1, 1'b0);
        check_val("ms_resume_flush", 32'(flush_if_id_o), 32'd1);
        check_val("ms_resume_mem_rd", 32'(mem_rd_addr_o), 32'd3);
        step(op_idle(), 1'b0, 1'b0);
        check_val("ms_flush_once", 32'(flush_cnt_o), 32'd2);
        check_val("ms_wb_rd", 32'(wb_rd_addr_o), 32'd3);

        // 20 back-to-back load-use events saturate the 4-bit counter at 15
        for (int k = 0; k < 40; k++) step(op_load(5'd7, 5'd7), 1'b0, 1'b0);
        step(op_idle(), 1'b0, 1'b0);
        check_val("sat_w4_stall", 32'(w4_stall_cnt), 32'd15);
        check_val("sat_w16_stall", 32'(stall_cnt_o), 32'd20);

        // random traffic with occasional mid-flight resets
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step(op_rand(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
